quad_encoder_emulator: RTL and testbench

Generates a quadrature A/B waveform on `enc_out[1:0]` that emulates a rotary encoder turning a commanded number of detents in a commanded direction. It is the driving end of the encoder interface: its output feeds the encoder input of the detent-counting decoder (on the bench or through the board loopback header). It also keeps a mirror position counter with the same 0..MAX_COUNT wrap rules, so the bench can compare it with the decoder's count.

---
 rtl/quad_encoder_emulator.sv | 188 ++++++++++++++++++
 tb/tb_quad_encoder_emulator.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_emulator.sv
// -----------------------------------------------------------------------------
// quad_encoder_emulator
//
// Emulates a rotary encoder turning a commanded number of detents. For every
// detent it walks the quadrature state enc_out through a 4-phase Gray sequence
// and returns to the rest state 2'b11:
//    cw : 11 -> 01 -> 00 -> 10 -> 11
//    ccw: 11 -> 10 -> 00 -> 01 -> 11
// Each phase is held PHASE_TICKS clocks. A mirror position counter (0..MAX_COUNT,
// wrapping) is updated on the same edge that re-enters 11.
//
// Parameters
//    PHASE_TICKS  clocks per quadrature state, 1..255
//    MAX_COUNT    highest position value before wrap
//
// Ports
//    clk_10k    in   system clock, rising edge
//    rst        in   asynchronous reset, active low
//    cmd_valid  in   command request
//    cmd_dir    in   1 = cw, 0 = ccw (sampled on accept)
//    cmd_steps  in   number of detents 0..1023 (sampled on accept)
//    cmd_ready  out  high in IDLE only
//    enc_out    out  registered quadrature state, rest = 2'b11
//    busy       out  high from accept until completion
//    done       out  one-cycle completion pulse
//    position   out  mirror detent counter 0..MAX_COUNT
// -----------------------------------------------------------------------------
module quad_encoder_emulator #(
   parameter int PHASE_TICKS = 5,
   parameter int MAX_COUNT   = 999
) (
   input  logic        clk_10k,
   input  logic        rst,
   input  logic        cmd_valid,
   input  logic        cmd_dir,
   input  logic [9:0]  cmd_steps,
   output logic        cmd_ready,
   output logic [1:0]  enc_out,
   output logic        busy,
   output logic        done,
   output logic [15:0] position
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   localparam logic [7:0]  TICK_LAST = 8'(PHASE_TICKS - 1);
   localparam logic [15:0] POS_MAX   = 16'(MAX_COUNT);

   state_t      state_q, state_d;
   logic [7:0]  tick_q, tick_d;
   logic [1:0]  phase_q, phase_d;        // 0..2 = non-rest phases, 3 = rest (11)
   logic [9:0]  remaining_q, remaining_d;
   logic        dir_q, dir_d;
   logic [1:0]  enc_q, enc_d;
   logic [15:0] pos_q, pos_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        ready_q, ready_d;

   // Quadrature code for phase index within a detent.
   function automatic logic [1:0] phase_code(input logic dir, input logic [1:0] idx);
      logic [1:0] code;
      case (idx)
         2'd0:    code = dir ? 2'b01 : 2'b10;
         2'd1:    code = 2'b00;
         2'd2:    code = dir ? 2'b10 : 2'b01;
         default: code = 2'b11;
      endcase
      return code;
   endfunction

   // Wrapping position step.
   function automatic logic [15:0] next_pos(input logic dir, input logic [15:0] pos);
      logic [15:0] res;
      if (dir) res = (pos >= POS_MAX) ? 16'd0 : pos + 16'd1;
      else     res = (pos == 16'd0) ? POS_MAX : pos - 16'd1;
      return res;
   endfunction

   always_comb begin
      state_d     = state_q;
      tick_d      = tick_q;
      phase_d     = phase_q;
      remaining_d = remaining_q;
      dir_d       = dir_q;
      enc_d       = enc_q;
      pos_d       = pos_q;
      busy_d      = busy_q;
      done_d      = done_q;
      ready_d     = ready_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               dir_d       = cmd_dir;
               remaining_d = cmd_steps;
               tick_d      = 8'd0;
               phase_d     = 2'd0;
               busy_d      = 1'b1;
               ready_d     = 1'b0;
               if (cmd_steps == 10'd0) begin
                  state_d = ST_FINISH;
               end else begin
                  state_d = ST_RUN;
                  enc_d   = phase_code(cmd_dir, 2'd0);
               end
            end
         end

         ST_RUN: begin
            if (tick_q == TICK_LAST) begin
               tick_d = 8'd0;
               if (phase_q != 2'd3) begin
                  phase_d = phase_q + 2'd1;
                  enc_d   = phase_code(dir_q, phase_q + 2'd1);
                  // Re-entering rest completes the detent.
                  if (phase_q == 2'd2) begin
                     pos_d       = next_pos(dir_q, pos_q);
                     remaining_d = remaining_q - 10'd1;
                  end
               end else if (remaining_q != 10'd0) begin
                  phase_d = 2'd0;
                  enc_d   = phase_code(dir_q, 2'd0);
               end else begin
                  state_d = ST_FINISH;
                  done_d  = 1'b1;
               end
            end else begin
               tick_d = tick_q + 8'd1;
            end
         end

         ST_FINISH: begin
            // A run enters FINISH with done already raised; a zero-step
            // command arrives with done low and raises it here first.
            if (done_q) begin
               done_d  = 1'b0;
               busy_d  = 1'b0;
               ready_d = 1'b1;
               state_d = ST_IDLE;
            end else begin
               done_d = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_10k or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         tick_q      <= 8'd0;
         phase_q     <= 2'd0;
         remaining_q <= 10'd0;
         dir_q       <= 1'b0;
         enc_q       <= 2'b11;
         pos_q       <= 16'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         phase_q     <= phase_d;
         remaining_q <= remaining_d;
         dir_q       <= dir_d;
         enc_q       <= enc_d;
         pos_q       <= pos_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ready_q     <= ready_d;
      end
   end

   assign cmd_ready = ready_q;
   assign enc_out   = enc_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign position  = pos_q;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
`timescale 1us/1ns
// -----------------------------------------------------------------------------
// tb_quad_encoder_emulator
//
// Directed bench. When a command is driven, the expected output snapshot for
// every phase start, phase end, completion and a few idle cycles afterwards is
// pushed to a scoreboard queue, tagged with the clock-edge number it follows.
// A monitor pops and compares entries on the falling edge.
// -----------------------------------------------------------------------------
module tb_quad_encoder_emulator;

   localparam int P   = 5;
   localparam int MAX = 999;

   logic        clk_10k = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_dir = 1'b0;
   logic [9:0]  cmd_steps = 10'd0;
   logic        cmd_ready;
   logic [1:0]  enc_out;
   logic        busy;
   logic        done;
   logic [15:0] position;

   quad_encoder_emulator #(.PHASE_TICKS(P), .MAX_COUNT(MAX)) dut (
      .clk_10k   (clk_10k),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_dir   (cmd_dir),
      .cmd_steps (cmd_steps),
      .cmd_ready (cmd_ready),
      .enc_out   (enc_out),
      .busy      (busy),
      .done      (done),
      .position  (position)
   );

   always #50 clk_10k = ~clk_10k;

   int cyc = 0;   // number of rising edges seen
   always @(posedge clk_10k) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [20:0] obs;   // {enc, pos, done, busy, ready}
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cmd_id = 0;
   logic [1:0] prev_enc = 2'b11;

   function automatic void add(input int c, input logic [1:0] e, input int p,
                               input logic d, input logic b, input logic r, input string tag);
      exp_t x;
      x.cyc = c;
      x.obs = {e, 16'(p), d, b, r};
      x.tag = tag;
      sb.push_back(x);
   endfunction

   // Pushes the expected timeline of one accepted command; returns final position.
   function automatic int push_cmd(input int t0, input bit dir, input int n, input int pos0);
      logic [1:0] seq [4];
      int pos;
      int f;
      pos = pos0;
      if (dir) seq = '{2'b01, 2'b00, 2'b10, 2'b11};
      else     seq = '{2'b10, 2'b00, 2'b01, 2'b11};
      if (n == 0) begin
         add(t0,     2'b11, pos, 1'b0, 1'b1, 1'b0, $sformatf("cmd%0d zero_accept", cmd_id));
         add(t0 + 1, 2'b11, pos, 1'b1, 1'b1, 1'b0, $sformatf("cmd%0d zero_done", cmd_id));
         f = t0 + 1;
      end else begin
         for (int k = 0; k < n; k++) begin
            for (int ph = 0; ph < 4; ph++) begin
               int c;
               c = t0 + 4*P*k + ph*P;
               if (ph == 3) pos = dir ? ((pos == MAX) ? 0 : pos + 1) : ((pos == 0) ? MAX : pos - 1);
               add(c,         seq[ph], pos, 1'b0, 1'b1, 1'b0, $sformatf("cmd%0d k%0d ph%0d_start", cmd_id, k, ph));
               add(c + P - 1, seq[ph], pos, 1'b0, 1'b1, 1'b0, $sformatf("cmd%0d k%0d ph%0d_end", cmd_id, k, ph));
            end
         end
         f = t0 + 4*P*n;
         add(f, 2'b11, pos, 1'b1, 1'b1, 1'b0, $sformatf("cmd%0d done", cmd_id));
      end
      add(f + 1, 2'b11, pos, 1'b0, 1'b0, 1'b1, $sformatf("cmd%0d ready", cmd_id));
      for (int i = 2; i < 5; i++)
         add(f + i, 2'b11, pos, 1'b0, 1'b0, 1'b1, $sformatf("cmd%0d idle%0d", cmd_id, i));
      cmd_id++;
      return pos;
   endfunction

   // Scoreboard monitor and Gray-code check.
   always @(negedge clk_10k) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t e;
         logic [20:0] act;
         e = sb.pop_front();
         act = {enc_out, position, done, busy, cmd_ready};
         checks++;
         assert (e.cyc == cyc && act === e.obs) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed enc/pos/done/busy/ready=%b/%0d/%b/%b/%b expected=%b/%0d/%b/%b/%b",
                   e.tag, cyc, act[20:19], act[18:3], act[2], act[1], act[0],
                   e.obs[20:19], e.obs[18:3], e.obs[2], e.obs[1], e.obs[0]);
         end
      end
      if (rst && enc_out !== prev_enc) begin
         checks++;
         assert ($countones(enc_out ^ prev_enc) == 1) else begin
            failures++;
            $error("FAIL gray cyc=%0d observed %b->%b expected one bit change", cyc, prev_enc, enc_out);
         end
      end
      prev_enc = enc_out;
   end

   // Bounded wait for the scoreboard to empty.
   task automatic drain(input string tag);
      for (int i = 0; i < 600 && sb.size() > 0; i++) @(negedge clk_10k);
      @(negedge clk_10k);
      checks++;
      assert (sb.size() == 0) else begin
         failures++;
         $error("FAIL drain_%s observed %0d pending expected 0", tag, sb.size());
         sb.delete();
      end
   endtask

   // Drives one command at a falling edge; the next rising edge accepts it.
   task automatic issue(input bit dir, input int n, input int pos0, output int t0, output int pos_end);
      cmd_valid = 1'b1;
      cmd_dir   = dir;
      cmd_steps = 10'(n);
      t0 = cyc + 1;
      pos_end = push_cmd(t0, dir, n, pos0);
      @(negedge clk_10k);
      cmd_valid = 1'b0;
      cmd_steps = 10'd0;
   endtask

   initial begin
      int t0;
      int pos;
      logic [20:0] act;

      // Reset state
      rst = 1'b0;
      repeat (3) @(negedge clk_10k);
      act = {enc_out, position, done, busy, cmd_ready};
      checks++;
      assert (act === {2'b11, 16'd0, 1'b0, 1'b0, 1'b1}) else begin
         failures++;
         $error("FAIL reset observed=%b expected=%b", act, {2'b11, 16'd0, 3'b001});
      end
      rst = 1'b1;
      @(negedge clk_10k);
      pos = 0;

      // 1: cw 1 step from 0
      issue(1'b1, 1, pos, t0, pos);
      drain("cw1");
      // bring position to 0 then check ccw wrap 0 -> 999
      issue(1'b0, 1, pos, t0, pos);
      drain("ccw_to0");
      issue(1'b0, 1, pos, t0, pos);
      drain("ccw_wrap");
      // 3: cw 3 steps from 998
      issue(1'b0, 1, pos, t0, pos);
      drain("ccw_to998");
      issue(1'b1, 3, pos, t0, pos);
      drain("cw3_wrap");
      // 4: zero steps
      issue(1'b1, 0, pos, t0, pos);
      drain("zero");
      // 5: cw 2 steps with an ignored mid-command request
      issue(1'b1, 2, pos, t0, pos);
      repeat (6) @(negedge clk_10k);
      cmd_valid = 1'b1;
      cmd_dir   = 1'b0;
      cmd_steps = 10'd5;
      @(negedge clk_10k);
      cmd_valid = 1'b0;
      cmd_steps = 10'd0;
      drain("cw2_ignored");

      // 6: reset mid-command from position 0
      rst = 1'b0;
      @(negedge clk_10k);
      rst = 1'b1;
      @(negedge clk_10k);
      cmd_valid = 1'b1;
      cmd_dir   = 1'b1;
      cmd_steps = 10'd1;
      @(negedge clk_10k);
      cmd_valid = 1'b0;
      cmd_steps = 10'd0;
      repeat (12) @(negedge clk_10k);
      checks++;
      assert (enc_out === 2'b10 && busy === 1'b1) else begin
         failures++;
         $error("FAIL pre_reset observed enc=%b busy=%b expected enc=10 busy=1", enc_out, busy);
      end
      #2 rst = 1'b0;
      #1;
      act = {enc_out, position, done, busy, cmd_ready};
      checks++;
      assert (act === {2'b11, 16'd0, 1'b0, 1'b0, 1'b1}) else begin
         failures++;
         $error("FAIL mid_reset observed=%b expected=%b", act, {2'b11, 16'd0, 3'b001});
      end
      @(negedge clk_10k);
      rst = 1'b1;
      repeat (3) @(negedge clk_10k);
      act = {enc_out, position, done, busy, cmd_ready};
      checks++;
      assert (act === {2'b11, 16'd0, 1'b0, 1'b0, 1'b1}) else begin
         failures++;
         $error("FAIL post_reset observed=%b expected=%b", act, {2'b11, 16'd0, 3'b001});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
